rand_hex_display: RTL and testbench
===================================

// Module: rand_hex_display
// PURPOSE
//  Downstream display stage for the random-number generator. Samples its 7-bit
//  result, converts it to two decimal digits with a sequential double-dabble,
//  and drives two active-low seven-segment displays (tens, ones).
//  Also reports when the value has stopped changing, i.e. the roll has finished.
// PARAMETERS
//  SETTLE_CYCLES  25_000_000  cycles of unchanged input before o_settled asserts (0.5 s @ 50 MHz)
//  BLANK_ZERO     1           1: a value of 0 (generator idle) blanks both digits; 0: shows " 0"
// PORTS
//  i_clk       in   1  system clock; one clock, all logic on posedge
//  i_rst       in   1  synchronous, active-high reset
//  i_value     in   7  generator result, 0..127, may change on any cycle
//  o_hex_tens  out  7  tens digit segments, active-low, bit0=a .. bit6=g
//  o_hex_ones  out  7  ones digit segments, active-low, bit0=a .. bit6=g
//  o_busy      out  1  high while a conversion is in flight (LOAD/CONV states)
//  o_settled   out  1  high once i_value has been unchanged for SETTLE_CYCLES
// BEHAVIOUR
//  - Reset: state IDLE; o_hex_* = 7'h7F (blank); o_busy=0; o_settled=0;
//    last-converted register r_last=0; settle counter=0. Reset mid-CONV aborts it.
//  - i_value registered every cycle into r_in (input sampler, edge k).
//  - FSM IDLE -> LOAD -> CONV(7 steps) -> DONE -> IDLE:
//    IDLE: if r_in != r_last, go LOAD at edge k+1: r_last<=r_in, shift reg
//          {bcd[7:0],bin[6:0]} <= {8'd0, r_in}, step counter <= 0.
//    CONV: edges k+2..k+8, one step per edge: add 3 to each BCD nibble >= 5,
//          then shift left 1. Step counter 0..6; leave after step 6.
//    DONE: edge k+9 registers o_hex_*; back to IDLE.
//  - Latency: new value on o_hex_* after edge k+9 (10 edges incl. sampling edge).
//  - o_busy is a registered output, high after edges k+1..k+8, low after edge k+9 (DONE).
//  - Input changes during LOAD/CONV/DONE are ignored; IDLE re-compares
//    r_in vs r_last and reconverts. The final displayed value always equals the
//    last stable input.
//  - Digit mapping at DONE (v = converted value):
//    v==0 && BLANK_ZERO: both 7'h7F.  v<=9: tens 7'h7F (leading blank).
//    10..99: both digits decoded.  100..127: both 7'b0111111 (dash, overflow).
//  - Segment codes 0-9: 40,79,24,30,19,12,02,78,00,10 (hex, active-low).
//  - Settle: counter clears to 0 whenever r_in differs from the previous r_in;
//    otherwise increments, saturating at SETTLE_CYCLES; o_settled =
//    (counter==SETTLE_CYCLES), registered. Counter width $clog2(SETTLE_CYCLES+1).
//  - Settle counter is independent of the FSM; o_settled may rise while the
//    last conversion is still in flight.
//  - No combinational path from i_value to any output.
// STRUCTURE
//  - Package rand_disp_pkg: state enum {IDLE,LOAD,CONV,DONE}, SEG_BLANK=7'h7F,
//    SEG_DASH=7'b0111111, seg digit constant table.
//  - Sub-module seg7_decoder (combinational 4-bit BCD -> 7-bit active-low),
//    instantiated twice; its outputs registered in rand_hex_display at DONE.
// TESTING  (SETTLE_CYCLES=8 for sim)
//  1 i_rst=1 for 2 cycles, i_value=0 -> o_hex_*=7F, o_busy=0; after 8 stable
//    cycles o_settled=1; no conversion ever starts (r_last==0).
//  2 i_value=42 at edge k -> o_busy=1 after edges k+1..k+8; after k+9
//    o_hex_tens=19, o_hex_ones=24, o_busy=0.
//  3 i_value=7 -> o_hex_tens=7F, o_hex_ones=78; i_value=127 -> both 3F.
//  4 42 at edge k then 93 at edge k+4 -> shows 42 after k+9, then reconverts;
//    final o_hex_tens=10, o_hex_ones=30; o_settled=0 until 93 stable 8 cycles.
//  5 i_rst pulsed at edge k+5 of a conversion -> next cycle o_hex_*=7F,
//    o_busy=0, o_settled=0; unchanged nonzero input then reconverts normally.
//  6 i_value toggling every cycle for 50 cycles -> o_settled stays 0; last
//    value displayed correctly within 20 cycles after toggling stops.

Source files
------------

// File: rtl/rand_disp_pkg.sv
// Shared types and constants for the random-number display stage.
// Holds the FSM encoding, segment patterns and the double-dabble step.
package rand_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CONV,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low patterns for digits 0..9, bit0=a .. bit6=g
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // One double-dabble step on {tens, ones, bin}: adjust nibbles, shift left.
    // The tens nibble can overflow for values >= 100; those are shown as dashes.
    function automatic logic [14:0] dd_step(input logic [14:0] s);
        logic [14:0] t;
        t = s;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        if (t[10:7] >= 4'd5) t[10:7] = t[10:7] + 4'd3;
        return {t[13:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment pattern.
// Codes above 9 map to a blank digit.
module seg7_decoder
    import rand_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    // Table lookup with a blank fallback for non-decimal codes
    always_comb begin
        seg_o = SEG_BLANK;
        if (bcd_i <= 4'd9) seg_o = SEG_DIGIT[bcd_i];
    end

endmodule

// File: rtl/rand_hex_display.sv
// Shows the generator result as two decimal digits on 7-seg displays
// and flags when the input has stopped changing.
module rand_hex_display
    import rand_disp_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 25_000_000,
    parameter bit          BLANK_ZERO    = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_value,
    output logic [6:0] o_hex_tens,
    output logic [6:0] o_hex_ones,
    output logic       o_busy,
    output logic       o_settled
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_CYCLES);

    state_t        state_q;
    logic [6:0]    r_in_q;
    logic [6:0]    r_prev_q;
    logic [6:0]    r_last_q;
    logic [14:0]   shift_q;
    logic [14:0]   shift_d;
    logic [2:0]    step_q;
    logic [6:0]    hex_tens_q;
    logic [6:0]    hex_ones_q;
    logic [6:0]    tens_d;
    logic [6:0]    ones_d;
    logic [6:0]    tens_seg;
    logic [6:0]    ones_seg;
    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic          settled_q;

    assign shift_d = dd_step(shift_q);

    seg7_decoder u_dec_tens (
        .bcd_i (shift_q[14:11]),
        .seg_o (tens_seg)
    );

    seg7_decoder u_dec_ones (
        .bcd_i (shift_q[10:7]),
        .seg_o (ones_seg)
    );

    // Final digit patterns: overflow dashes, zero blanking, leading blank
    always_comb begin
        tens_d = tens_seg;
        ones_d = ones_seg;
        if (r_last_q >= 7'd100) begin
            tens_d = SEG_DASH;
            ones_d = SEG_DASH;
        end else if (BLANK_ZERO && r_last_q == 7'd0) begin
            tens_d = SEG_BLANK;
            ones_d = SEG_BLANK;
        end else if (r_last_q <= 7'd9) begin
            tens_d = SEG_BLANK;
        end
    end

    // Input sampler; previous sample feeds the settle detector
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_q   <= '0;
            r_prev_q <= '0;
        end else begin
            r_in_q   <= i_value;
            r_prev_q <= r_in_q;
        end
    end

    // Settle counter: restarts on any change, saturates at the limit
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            settled_q <= 1'b0;
        end else begin
            if (r_in_q != r_prev_q) begin
                cnt_q <= '0;
            end else if (cnt_q != SETTLE_MAX) begin
                cnt_q <= cnt_q + CW'(1);
            end
            settled_q <= (cnt_q == SETTLE_MAX);
        end
    end

    // Conversion FSM: load, seven dabble steps, then latch the digits
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            r_last_q   <= '0;
            shift_q    <= '0;
            step_q     <= '0;
            busy_q     <= 1'b0;
            hex_tens_q <= SEG_BLANK;
            hex_ones_q <= SEG_BLANK;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (r_in_q != r_last_q) begin
                        r_last_q <= r_in_q;
                        shift_q  <= {8'd0, r_in_q};
                        step_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= LOAD;
                    end
                end
                LOAD: begin
                    shift_q <= shift_d;
                    step_q  <= 3'd1;
                    state_q <= CONV;
                end
                CONV: begin
                    shift_q <= shift_d;
                    step_q  <= step_q + 3'd1;
                    if (step_q == 3'd6) state_q <= DONE;
                end
                DONE: begin
                    hex_tens_q <= tens_d;
                    hex_ones_q <= ones_d;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_hex_tens = hex_tens_q;
    assign o_hex_ones = hex_ones_q;
    assign o_busy     = busy_q;
    assign o_settled  = settled_q;

endmodule

// File: tb/tb_rand_hex_display.sv
// Directed bench for rand_hex_display with a short settle window.
// Outputs are sampled 1 ns after each rising edge.
module tb_rand_hex_display;

    logic       clk;
    logic       rst;
    logic [6:0] value;
    logic [6:0] hex_tens;
    logic [6:0] hex_ones;
    logic       busy;
    logic       settled;

    int npass;
    int ntot;

    rand_hex_display #(
        .SETTLE_CYCLES (8),
        .BLANK_ZERO    (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_value    (value),
        .o_hex_tens (hex_tens),
        .o_hex_ones (hex_ones),
        .o_busy     (busy),
        .o_settled  (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] obs,
                         input logic [6:0] exp);
        ntot++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply a value, wait through the 10-edge latency, check the digits
    task automatic conv(input string tag, input logic [6:0] v,
                        input logic [6:0] et, input logic [6:0] eo);
        value = v;
        repeat (10) tick();
        check({tag, "_tens"}, hex_tens, et);
        check({tag, "_ones"}, hex_ones, eo);
        check({tag, "_busy"}, {6'd0, busy}, 7'd0);
    endtask

    initial begin
        npass = 0;
        ntot  = 0;
        rst   = 1'b1;
        value = 7'd0;

        // 1: reset state, settle on idle zero input
        tick();
        tick();
        check("rst_tens", hex_tens, 7'h7F);
        check("rst_ones", hex_ones, 7'h7F);
        check("rst_busy", {6'd0, busy}, 7'd0);
        check("rst_settled", {6'd0, settled}, 7'd0);
        rst = 1'b0;
        repeat (8) tick();
        check("settle_early", {6'd0, settled}, 7'd0);
        tick();
        check("settle_on", {6'd0, settled}, 7'd1);
        check("idle_busy", {6'd0, busy}, 7'd0);
        check("idle_tens", hex_tens, 7'h7F);

        // 2: busy window and latency for 42
        value = 7'd42;
        tick();
        check("busy_k", {6'd0, busy}, 7'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            check("busy_win", {6'd0, busy}, 7'd1);
        end
        tick();
        check("v42_tens", hex_tens, 7'h19);
        check("v42_ones", hex_ones, 7'h24);
        check("v42_busy", {6'd0, busy}, 7'd0);

        // 3: leading blank, boundaries, overflow, zero blanking
        conv("v7", 7'd7, 7'h7F, 7'h78);
        conv("v127", 7'd127, 7'h3F, 7'h3F);
        conv("v10", 7'd10, 7'h79, 7'h40);
        conv("v99", 7'd99, 7'h10, 7'h10);
        conv("v100", 7'd100, 7'h3F, 7'h3F);
        conv("v9", 7'd9, 7'h7F, 7'h10);
        conv("v0", 7'd0, 7'h7F, 7'h7F);

        // 4: change during conversion is picked up afterwards
        value = 7'd42;
        repeat (4) tick();
        value = 7'd93;
        repeat (6) tick();
        check("mid_tens", hex_tens, 7'h19);
        check("mid_ones", hex_ones, 7'h24);
        check("mid_settled", {6'd0, settled}, 7'd0);
        repeat (4) tick();
        check("s93_edge", {6'd0, settled}, 7'd0);
        tick();
        check("s93_on", {6'd0, settled}, 7'd1);
        repeat (5) tick();
        check("v93_tens", hex_tens, 7'h10);
        check("v93_ones", hex_ones, 7'h30);
        check("v93_busy", {6'd0, busy}, 7'd0);

        // 5: reset in the middle of a conversion
        value = 7'd42;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("abort_tens", hex_tens, 7'h7F);
        check("abort_ones", hex_ones, 7'h7F);
        check("abort_busy", {6'd0, busy}, 7'd0);
        check("abort_settled", {6'd0, settled}, 7'd0);
        rst = 1'b0;
        repeat (10) tick();
        check("re42_tens", hex_tens, 7'h19);
        check("re42_ones", hex_ones, 7'h24);

        // 6: input changing every cycle never settles
        for (int i = 0; i < 50; i++) begin
            value = 7'((i * 37 + 11) % 128);
            tick();
            if (i >= 3) check("toggle_settled", {6'd0, settled}, 7'd0);
        end
        value = 7'd56;
        repeat (20) tick();
        check("v56_tens", hex_tens, 7'h12);
        check("v56_ones", hex_ones, 7'h02);
        check("v56_busy", {6'd0, busy}, 7'd0);
        check("v56_settled", {6'd0, settled}, 7'd1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
